dmem_ctrl: RTL and testbench

Parametrised data-memory controller for the RISC-V core. It replaces the bare combinational load/store path (fixed 32-bit array, raw byte-enables, zero-latency read) with a byte-addressed word memory that has a valid/ready request channel, a valid/ready response channel and a configurable read latency. Loads are sign/zero-extended in-block per funct3, and stores are lane-steered. It sits between the execute stage (L-type/S-type decode) and the register-file write-back.

---
 rtl/dmem_ctrl_if.sv | 34 +++
 rtl/dmem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// ============================================================================
// Module : dmem_ctrl_if
// Brief  : Request/response channel between execute stage and dmem_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module : dmem_ctrl
// Brief  : Byte-addressed word data memory with valid/ready request and
//          response channels, configurable read latency and RV32 load
//          extension. Optional macro: DMEM_MISALIGN_TRAP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);

  localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [1:0] c_CNT_INIT = 2'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_WAIT = 2'd1,
    S_RESP      = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [1:0]         r_cnt;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_fault;
  logic [31:0]        r_rsp_rdata;
  logic               r_busy;

  logic               w_is_b;
  logic               w_is_h;
  logic [1:0]         w_raw_off;
  logic [1:0]         w_off;
  logic               w_misalign;
  logic               w_trap;
  logic               w_accept;
  logic               w_mem_we;
  logic [c_IDX_W-1:0] w_idx;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic [31:0]        w_rd_word;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic               w_unused_addr;

  assign w_is_b    = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b100);
  assign w_is_h    = (bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101);
  assign w_raw_off = bus.req_addr[1:0];
  assign w_misalign = w_is_h ? w_raw_off[0] : (!w_is_b && (w_raw_off != 2'b00));
  // Force-aligned lane offset; only matters when the access is not trapped.
  assign w_off     = w_is_b ? w_raw_off : (w_is_h ? {w_raw_off[1], 1'b0} : 2'b00);
  assign w_idx     = bus.req_addr[c_IDX_W+1:2];
  assign w_unused_addr = ^bus.req_addr;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_mem_we  = w_accept && bus.req_we && !w_trap && !reset;
  assign w_rd_idx  = (r_state == S_IDLE) ? w_idx : r_idx;
  assign w_rd_word = r_mem[w_rd_idx];

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata;
    if (w_is_b) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{bus.req_wdata[7:0]}};
    end else if (w_is_h) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.req_wdata[15:0]}};
    end
  end

  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  f_extract = {{24{b[7]}}, b};
      3'b100:  f_extract = {24'd0, b};
      3'b001:  f_extract = {{16{h[15]}}, h};
      3'b101:  f_extract = {16'd0, h};
      default: f_extract = word;
    endcase
  endfunction

  // Storage has no reset; contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_idx       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3    <= bus.req_funct3;
            r_off       <= w_off;
            r_idx       <= w_idx;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= 32'd0;
            if (w_trap) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
            end else if (bus.req_we) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else if (RD_LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= f_extract(w_rd_word, bus.req_funct3, w_off);
            end else begin
              r_state <= S_READ_WAIT;
              r_cnt   <= c_CNT_INIT;
            end
          end
        end
        S_READ_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= f_extract(w_rd_word, r_funct3, r_off);
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module : tb_dmem_ctrl
// Brief  : Directed scoreboard bench for dmem_ctrl (RD_LATENCY = 3).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

  localparam int c_DEPTH = 1024;
  localparam int c_AW    = 32;
  localparam int c_LAT   = 3;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  dmem_ctrl_if #(.ADDR_W(c_AW)) bus ();

  dmem_ctrl #(
    .DEPTH_WORDS (c_DEPTH),
    .ADDR_W      (c_AW),
    .RD_LATENCY  (c_LAT)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_fault,
                     input int exp_lat, input int hold);
    exp_t e;
    int   n;
    e.data  = exp_data;
    e.fault = exp_fault;
    e.lat   = exp_lat;
    sb.push_back(e);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    // Scramble fields after acceptance; the DUT must ignore them.
    bus.req_valid = 1'b0;
    bus.req_addr  = addr ^ 32'h0000_0004;
    bus.req_wdata = ~wdata;
    bus.req_funct3 = 3'b010;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no rsp_valid expected response", tag);
      bus.rsp_ready = 1'b1;
      return;
    end
    check({tag, "_lat"},   n,                            e.lat);
    check({tag, "_data"},  bus.rsp_rdata,                e.data);
    check({tag, "_fault"}, {31'd0, bus.rsp_fault},       {31'd0, e.fault});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({tag, "_hold_data"},  bus.rsp_rdata,          e.data);
      check({tag, "_hold_rdy"},   {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rdata",     bus.rsp_rdata,          32'd0);
    check("rst_fault",     {31'd0, bus.rsp_fault}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of READ_WAIT drops the response.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    end

    // Byte store and extended loads
    txn("sw10",  1'b1, 3'b010, 32'h10, 32'h8000_00FF, 32'h0, 1'b0, 0, 0);
    txn("sb11",  1'b1, 3'b000, 32'h11, 32'h0000_0080, 32'h0, 1'b0, 0, 0);
    txn("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0, c_LAT-1, 0);
    txn("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0080, 1'b0, c_LAT-1, 0);
    txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_80FF, 1'b0, c_LAT-1, 0);
    txn("ill10", 1'b0, 3'b011, 32'h10, 32'h0, 32'h8000_80FF, 1'b0, c_LAT-1, 0);

    // Half-word
    txn("sw20",  1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 0, 0);
    txn("sh22",  1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0, 0, 0);
    txn("lh22",  1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0, c_LAT-1, 0);
    txn("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_BEEF, 1'b0, c_LAT-1, 0);
    txn("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_3344, 1'b0, c_LAT-1, 0);
    txn("sb23",  1'b1, 3'b000, 32'h23, 32'h0000_007F, 32'h0, 1'b0, 0, 0);
    txn("lb23",  1'b0, 3'b000, 32'h23, 32'h0, 32'h0000_007F, 1'b0, c_LAT-1, 0);

    // Latency and backpressure
    txn("lw20bp", 1'b0, 3'b010, 32'h20, 32'h0, 32'h7FEF_3344, 1'b0, c_LAT-1, 5);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 0, 0);
    txn("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 0, 0);
    txn("sw13", 1'b1, 3'b010, 32'h13, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, 0);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_80FF, 1'b0, c_LAT-1, 0);
`else
    txn("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 32'h8000_80FF, 1'b0, c_LAT-1, 0);
    txn("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'hFFFF_80FF, 1'b0, c_LAT-1, 0);
`endif

    // Wrap-around
    txn("sw1000", 1'b1, 3'b010, 32'h1000, 32'h1234_5678, 32'h0, 1'b0, 0, 0);
    txn("lw0000", 1'b0, 3'b010, 32'h0000, 32'h0, 32'h1234_5678, 1'b0, c_LAT-1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
